// File: rtl/vx_alu_dotp_pkg.sv
// Shared definitions for the packed-integer dot-product unit: element
// formats and how many elements fit in the 32-bit operand slice.
package vx_alu_dotp_pkg;

  typedef enum logic [1:0] {
    FMT_U8 = 2'd0,
    FMT_S8 = 2'd1,
    FMT_U4 = 2'd2,
    FMT_S4 = 2'd3
  } dotp_fmt_e;

  localparam int INT8_ELEMS = 4;
  localparam int INT4_ELEMS = 8;

endpackage

// File: rtl/vx_alu_dotp_lane.sv
// One lane of the dot product: multiply packed elements of a and b, reduce,
// and optionally accumulate c. Purely combinational; wraps modulo 2^XLEN.
module vx_alu_dotp_lane
  import vx_alu_dotp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  input  logic [1:0]      fmt,
  input  logic            acc_en,
  output logic [XLEN-1:0] result
);

  logic                sgn;
  logic                is_int4;
  logic signed [8:0]   a8, b8;
  logic signed [17:0]  p8;
  logic signed [4:0]   a4, b4;
  logic signed [9:0]   p4;
  logic [XLEN-1:0]     sum8, sum4;

  // Elements are widened by one bit (zero or sign) so a single signed
  // multiplier handles both signed and unsigned formats.
  always_comb begin
    sgn     = (fmt == FMT_S8) || (fmt == FMT_S4);
    is_int4 = (fmt == FMT_U4) || (fmt == FMT_S4);
    a8   = '0;
    b8   = '0;
    p8   = '0;
    a4   = '0;
    b4   = '0;
    p4   = '0;
    sum8 = '0;
    sum4 = '0;
    for (int k = 0; k < INT8_ELEMS; k++) begin
      a8   = {sgn & a[8*k+7], a[8*k +: 8]};
      b8   = {sgn & b[8*k+7], b[8*k +: 8]};
      p8   = a8 * b8;
      sum8 = sum8 + {{(XLEN-18){p8[17]}}, p8};
    end
    for (int k = 0; k < INT4_ELEMS; k++) begin
      a4   = {sgn & a[4*k+3], a[4*k +: 4]};
      b4   = {sgn & b[4*k+3], b[4*k +: 4]};
      p4   = a4 * b4;
      sum4 = sum4 + {{(XLEN-10){p4[9]}}, p4};
    end
    result = (is_int4 ? sum4 : sum8) + (acc_en ? c : '0);
  end

endmodule

// File: rtl/vx_alu_dotp.sv
// Pipelined multi-lane dot-product ALU with valid/ready handshake. The lanes
// compute into stage 0; remaining stages are an elastic shift pipeline.
module vx_alu_dotp
  import vx_alu_dotp_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [1:0]                fmt,
  input  logic                      acc_en,
  input  logic [NUM_LANES*XLEN-1:0] rs1_data,
  input  logic [NUM_LANES*XLEN-1:0] rs2_data,
  input  logic [NUM_LANES*XLEN-1:0] rs3_data,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [TAG_WIDTH-1:0]      tag_out
);

  localparam int DW = NUM_LANES * XLEN;

  logic [DW-1:0]        lane_res;
  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [LATENCY-1:0]   adv;
  logic [LATENCY-1:0]   load;
  logic [DW-1:0]        data_q [LATENCY];
  logic [TAG_WIDTH-1:0] tag_q  [LATENCY];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_alu_dotp_lane #(.XLEN(XLEN)) u_lane (
      .a      (rs1_data[l*XLEN +: XLEN]),
      .b      (rs2_data[l*XLEN +: XLEN]),
      .c      (rs3_data[l*XLEN +: XLEN]),
      .fmt    (fmt),
      .acc_en (acc_en),
      .result (lane_res[l*XLEN +: XLEN])
    );
  end

  // A stage can move unless it and every stage downstream of it is full
  // while the consumer stalls; this collapses bubbles without a ripple chain.
  for (genvar i = 0; i < LATENCY; i++) begin : g_adv
    assign adv[i] = ready_out || !(&valid_q[LATENCY-1:i]);
  end

  always_comb begin
    valid_d    = valid_q;
    load       = '0;
    valid_d[0] = adv[0] ? valid_in : valid_q[0];
    load[0]    = adv[0] && valid_in;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = adv[i] ? valid_q[i-1] : valid_q[i];
      load[i]    = adv[i] && valid_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (load[0]) begin
        data_q[0] <= lane_res;
        tag_q[0]  <= tag_in;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (load[i]) begin
          data_q[i] <= data_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end
  end

  assign ready_in  = adv[0];
  assign valid_out = valid_q[LATENCY-1];
  assign data_out  = data_q[LATENCY-1];
  assign tag_out   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_vx_alu_dotp.sv
// Scoreboard bench for vx_alu_dotp: 4 lanes, LATENCY=2, directed vectors,
// backpressure, mid-flight reset and randomized traffic against a plain-math model.
module tb_vx_alu_dotp;

  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 2;
  localparam int TW  = 8;
  localparam int DW  = NL * XL;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready_in;
  logic [1:0]    fmt;
  logic          acc_en;
  logic [DW-1:0] rs1_data, rs2_data, rs3_data;
  logic [TW-1:0] tag_in;
  logic          valid_out;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;

  vx_alu_dotp #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .fmt       (fmt),
    .acc_en    (acc_en),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rs3_data  (rs3_data),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            acc_cyc;
    bit            lat_chk;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            rdy_low = 0;
  logic [TW-1:0] tag_cnt = '0;
  bit            cur_has_exp;
  logic [31:0]   cur_exp0;
  bit            cur_lat;
  bit            rand_done;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: unpack elements with integer shifts/masks, sum in 64 bits, truncate.
  function automatic logic [31:0] ref_dot(input logic [1:0] f, input logic acc,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    longint s;
    int w, n, half, ea, eb;
    bit is_signed;
    is_signed = (f == 2'd1) || (f == 2'd3);
    w    = (f >= 2'd2) ? 4 : 8;
    n    = 32 / w;
    half = 1 << (w - 1);
    s    = acc ? longint'(c) : 0;
    for (int k = 0; k < n; k++) begin
      ea = int'((a >> (k * w)) & ((32'd1 << w) - 1));
      eb = int'((b >> (k * w)) & ((32'd1 << w) - 1));
      if (is_signed && ea >= half) ea -= 2 * half;
      if (is_signed && eb >= half) eb -= 2 * half;
      s += longint'(ea) * longint'(eb);
    end
    return s[31:0];
  endfunction

  // Monitor/scoreboard
  bit            hold_prev = 0;
  logic [DW-1:0] prev_data;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    if (!reset) begin
      hold_prev = 0;
    end else begin
      int occ;
      occ = sb.size();
      chk(ready_in == (ready_out || occ < LAT), "ready_in_vs_occupancy", DW'(ready_in), DW'(occ));
      if (!ready_in) rdy_low++;
      if (hold_prev) begin
        chk(valid_out == 1'b1, "stall_valid_hold", DW'(valid_out), DW'(1));
        chk(data_out == prev_data, "stall_data_hold", data_out, prev_data);
        chk(tag_out == prev_tag, "stall_tag_hold", DW'(tag_out), DW'(prev_tag));
      end
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", DW'(tag_out), '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(data_out == e.data, "data", data_out, e.data);
          chk(tag_out == e.tag, "tag", DW'(tag_out), DW'(e.tag));
          if (e.lat_chk) chk(cyc - e.acc_cyc == LAT, "latency", DW'(cyc - e.acc_cyc), DW'(LAT));
        end
      end
      hold_prev = valid_out && !ready_out;
      prev_data = data_out;
      prev_tag  = tag_out;
      if (valid_in && ready_in) begin
        exp_t e;
        for (int l = 0; l < NL; l++)
          e.data[l*XL +: XL] = ref_dot(fmt, acc_en, rs1_data[l*XL +: XL],
                                       rs2_data[l*XL +: XL], rs3_data[l*XL +: XL]);
        if (cur_has_exp) e.data[XL-1:0] = cur_exp0;
        e.tag     = tag_in;
        e.acc_cyc = cyc;
        e.lat_chk = cur_lat;
        sb.push_back(e);
      end
    end
  end

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*XL +: XL] = $urandom;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge following acceptance.
  task automatic send(input logic [1:0] f, input logic acc, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input bit has_exp, input logic [31:0] exp0, input bit lat);
    int n;
    fmt = f; acc_en = acc; rs1_data = a; rs2_data = b; rs3_data = c;
    tag_in = tag_cnt; cur_has_exp = has_exp; cur_exp0 = exp0; cur_lat = lat;
    valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_in && n < 200);
    if (!ready_in) chk(1'b0, "accept_timeout", DW'(n), DW'(200));
    @(posedge clk); #1;
    valid_in = 1'b0;
    tag_cnt++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(sb.size() == 0, "drain", DW'(sb.size()), '0);
  endtask

  logic [1:0]  d_fmt [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
  logic        d_acc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] d_a   [5] = '{32'h04030201, 32'hFFFFFFFF, 32'h88888888, 32'hFFFFFFFF, 32'h00000001};
  logic [31:0] d_b   [5] = '{32'h01010101, 32'h02020202, 32'h77777777, 32'hFFFFFFFF, 32'h00000001};
  logic [31:0] d_c   [5] = '{32'd0, 32'd0, 32'd0, 32'd100, 32'hFFFFFFFF};
  logic [31:0] d_exp [5] = '{32'h0000000A, 32'hFFFFFFF8, 32'hFFFFFE40, 32'h0003F868, 32'h00000000};

  initial begin
    logic [DW-1:0] a, b, c;
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1; fmt = '0; acc_en = 1'b0;
    rs1_data = '0; rs2_data = '0; rs3_data = '0; tag_in = '0;
    cur_has_exp = 0; cur_exp0 = '0; cur_lat = 0; rand_done = 0;
    repeat (2) @(negedge clk);
    chk(valid_out == 1'b0, "reset_valid_out", DW'(valid_out), '0);
    chk(ready_in == 1'b1, "reset_ready_in", DW'(ready_in), DW'(1));
    chk(data_out == '0, "reset_data_out", data_out, '0);
    chk(tag_out == '0, "reset_tag_out", DW'(tag_out), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on lane 0, random operands on the other lanes.
    for (int i = 0; i < 5; i++) begin
      a = rnd_vec(); b = rnd_vec(); c = rnd_vec();
      a[31:0] = d_a[i]; b[31:0] = d_b[i]; c[31:0] = d_c[i];
      send(d_fmt[i], d_acc[i], a, b, c, 1'b1, d_exp[i], 1'b1);
      repeat (3) @(posedge clk);
      #1;
    end
    drain();

    // Ten back-to-back beats with the consumer stalled for five cycles.
    tag_cnt = '0;
    rdy_low = 0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_out = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++)
          send(2'($urandom_range(0, 3)), 1'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, '0, 1'b0);
      end
    join
    drain();
    chk(rdy_low > 0, "ready_in_drop", DW'(rdy_low), DW'(1));

    // Reset while two beats are held in the pipeline.
    ready_out = 1'b0;
    send(2'd0, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, '0, 1'b0);
    send(2'd1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, '0, 1'b0);
    chk(sb.size() == 2, "inflight_count", DW'(sb.size()), DW'(2));
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk(valid_out == 1'b0, "midreset_valid_out", DW'(valid_out), '0);
    chk(ready_in == 1'b1, "midreset_ready_in", DW'(ready_in), DW'(1));
    chk(data_out == '0, "midreset_data_out", data_out, '0);
    chk(tag_out == '0, "midreset_tag_out", DW'(tag_out), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(valid_out == 1'b0, "post_reset_no_output", DW'(valid_out), '0);
    end
    @(posedge clk); #1;
    a = rnd_vec(); b = rnd_vec(); c = rnd_vec();
    send(2'd2, 1'b1, a, b, c, 1'b0, '0, 1'b1);
    drain();

    // Randomized traffic with random consumer stalls and input gaps.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
      begin
        for (int i = 0; i < 80; i++) begin
          send(2'($urandom_range(0, 3)), 1'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, '0, 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_alu_dotp.md
VX_ALU_DOTP -- requirements
Module: VX_alu_dotp

Interface
REQ-001 Parameter NUM_LANES, default 1: number of parallel lanes per issue.
REQ-002 Parameter XLEN, default 32: lane data width; legal values 32 and 64.
REQ-003 Parameter LATENCY, default 2: pipeline depth in stages; legal range 1..8.
REQ-004 Parameter TAG_WIDTH, default 1: opaque sideband width carried alongside each beat.
REQ-005 clk  in  1: single clock; all state is updated on its rising edge.
REQ-006 reset  in  1: asynchronous, active-low reset.
REQ-007 valid_in  in  1: an input beat is present.
REQ-008 ready_in  out  1: the block accepts the input beat this cycle.
REQ-009 fmt  in  2: element format; 0=INT8 unsigned, 1=INT8 signed, 2=INT4 unsigned, 3=INT4 signed.
REQ-010 acc_en  in  1: add rs3 to the dot product.
REQ-011 rs1_data, rs2_data, rs3_data  in  NUM_LANES x XLEN: operands A, B and accumulator C.
REQ-012 tag_in  in  TAG_WIDTH: sideband value for the beat.
REQ-013 valid_out  out  1: a result beat is present.
REQ-014 ready_out  in  1: the consumer accepts the result beat.
REQ-015 data_out  out  NUM_LANES x XLEN: per-lane results.
REQ-016 tag_out  out  TAG_WIDTH: the tag_in value of the beat, returned unchanged.

Function
REQ-017 Operands SHALL come from bits [31:0] of rs1/rs2 only; INT8 uses 4 elements (byte k = bits 8k+7:8k), INT4 uses 8 elements (nibble k = bits 4k+3:4k).
REQ-018 Each element product SHALL be zero- or sign-extended to XLEN according to fmt; the sum of all products plus (acc_en ? rs3 : 0) SHALL be computed modulo 2^XLEN.
REQ-019 fmt and acc_en SHALL apply to all lanes of a beat and SHALL be captured together with the data on acceptance.
REQ-020 A beat is accepted when valid_in && ready_in; it is delivered when valid_out && ready_out.
REQ-021 Without backpressure, the result of a beat accepted in cycle t SHALL appear with valid_out=1 in cycle t+LATENCY.
REQ-022 Sustained throughput SHALL be one beat per cycle while ready_out stays high.
REQ-023 Each stage SHALL advance when it is empty or when the next stage advances; the last stage advances on ready_out. Bubbles SHALL collapse under stall.
REQ-024 ready_in SHALL equal !stage0_valid || stage0_advances; ready_in SHALL NOT depend combinationally on valid_in.
REQ-025 Under stall, a valid stage SHALL hold its data and tag stable; beats SHALL NOT be lost, duplicated or reordered.
REQ-026 valid_out, data_out and tag_out SHALL remain stable while valid_out=1 and ready_out=0.
REQ-027 Multiplies SHALL occur in stage 0; the lane reduction and accumulate SHALL be registered by stage LATENCY-1. When LATENCY=1, the whole computation SHALL take place in a single stage.

Reset
REQ-028 While reset=0, all stage valid bits, data registers and tag registers SHALL clear to 0, so valid_out=0, data_out=0, tag_out=0 and ready_in=1.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats; no result SHALL emerge after reset is released.

Structure
REQ-030 Package VX_dotp_pkg SHALL hold the fmt encodings (FMT_U8, FMT_S8, FMT_U4, FMT_S4) and the element count constants.
REQ-031 A combinational sub-module VX_dotp_lane (a, b, c, fmt, acc_en -> result) SHALL be instanced NUM_LANES times; the pipeline registers and handshake logic SHALL reside in VX_alu_dotp.

Verification
REQ-032 fmt=0, rs1=0x04030201, rs2=0x01010101, acc_en=0 -> data_out=0x0000000A after exactly LATENCY cycles.
REQ-033 fmt=1, rs1=0xFFFFFFFF, rs2=0x02020202 -> 0xFFFFFFF8; fmt=3, rs1=0x88888888, rs2=0x77777777 -> 0xFFFFFE40.
REQ-034 fmt=0, rs1=rs2=0xFFFFFFFF, acc_en=1, rs3=100 -> 0x0003F868; acc_en=1, rs3=0xFFFFFFFF, product 1 -> 0x00000000 (wrap-around).
REQ-035 LATENCY=2, 10 back-to-back beats with tags 0..9, ready_out held low for cycles 3..7 -> ready_in drops once 2 beats are held; all 10 beats are delivered in order with matching tags and no duplicates.
REQ-036 Reset asserted while 2 beats are in flight -> valid_out=0 and ready_in=1 during reset; no output after release; the next beat returns after LATENCY cycles.
REQ-037 NUM_LANES=4 with distinct per-lane operands and mixed fmt across consecutive beats -> each lane matches the reference model on every beat.
